// File: rtl/sc_level_progress_counter_pkg.sv
// Shared definitions for the level progress counter and the level state machine.
package sc_level_progress_counter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PLAY    = 3'd1,
        ST_ADVANCE = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DONE    = 3'd4
    } lvl_state_t;

    localparam int unsigned LEVEL_MAX_C   = 7;
    localparam int unsigned NO_LEVEL_C    = 0;
    localparam int unsigned END_LEVEL_C   = 7;

    // Progress thresholds the level FSM compares LvlProgressCount_Out against.
    localparam int unsigned PROGRESS_THRESH_LO_C  = 18;
    localparam int unsigned PROGRESS_THRESH_MID_C = 23;
    localparam int unsigned PROGRESS_THRESH_HI_C  = 30;

endpackage

// File: rtl/sc_level_progress_counter_progress.sv
// Saturating progress counter: a shift strobe arms one increment, a later count strobe commits it.
module sc_progress_counter
    import sc_level_progress_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             shift_low,
    input  logic             count_low,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             pending_q, pending_d;

    // Next count/pending: clear wins, then strobes apply only while enabled.
    always_comb begin
        count_d   = count_q;
        pending_d = pending_q;
        if (clear) begin
            count_d   = '0;
            pending_d = 1'b0;
        end else if (enable) begin
            // Count consumes the pending flag held on entry to this cycle.
            if (!count_low && pending_q && (count_q != '1)) begin
                count_d = count_q + WIDTH'(1);
            end
            if (!shift_low) begin
                pending_d = 1'b1;
            end else if (!count_low) begin
                pending_d = 1'b0;
            end
        end
    end

    // Counter and pending flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sc_level_progress_counter.sv
// Level sequencing and progress register bank behind the level state machine.
module sc_level_progress_counter
    import sc_level_progress_counter_pkg::*;
#(
    parameter int unsigned LEVEL_DATAWIDTH    = 3,
    parameter int unsigned PROGRESS_DATAWIDTH = 5,
    parameter int unsigned LEVEL_MAX          = LEVEL_MAX_C
) (
    input  logic                          SC_LEVEL_STATEMACHINE_CLOCK_50,
    input  logic                          SC_LEVEL_STATEMACHINE_RESET_InHigh,
    input  logic                          Start_InLow,
    input  logic                          ProgressShift_InLow,
    input  logic                          ProgressCount_InLow,
    input  logic                          LevelFinished_InLow,
    input  logic                          FinishedGame_InLow,
    output logic [LEVEL_DATAWIDTH-1:0]    CurrentLevel_Out,
    output logic [PROGRESS_DATAWIDTH-1:0] LvlProgressCount_Out,
    output logic                          LevelAdvance_OutLow,
    output logic                          GameOver_OutHigh
);

    localparam logic [LEVEL_DATAWIDTH-1:0] LVL_MAX  = LEVEL_DATAWIDTH'(LEVEL_MAX);
    localparam logic [LEVEL_DATAWIDTH-1:0] LVL_NONE = LEVEL_DATAWIDTH'(NO_LEVEL_C);
    localparam logic [LEVEL_DATAWIDTH-1:0] LVL_ONE  = LEVEL_DATAWIDTH'(1);

    lvl_state_t                 state_q, state_d;
    logic [LEVEL_DATAWIDTH-1:0] level_q, level_d;
    logic                       adv_low_q, adv_low_d;
    logic                       game_over_q, game_over_d;
    logic                       prog_clear;
    logic                       prog_enable;

    // Next state, level and progress-counter controls; exits from PLAY discard that cycle's strobes.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        prog_clear  = 1'b0;
        prog_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                prog_clear = 1'b1;
                level_d    = LVL_NONE;
                if (!Start_InLow) begin
                    state_d = ST_PLAY;
                    level_d = LVL_ONE;
                end
            end
            ST_PLAY: begin
                if (!FinishedGame_InLow) begin
                    state_d = ST_DONE;
                end else if (!LevelFinished_InLow) begin
                    state_d = ST_ADVANCE;
                end else begin
                    prog_enable = 1'b1;
                end
            end
            ST_ADVANCE: begin
                prog_clear = 1'b1;
                if (level_q != LVL_MAX) begin
                    level_d = level_q + LVL_ONE;
                end
                state_d = (level_d == LVL_MAX) ? ST_DONE : ST_HOLD;
            end
            ST_HOLD: begin
                if (!FinishedGame_InLow) begin
                    state_d = ST_DONE;
                end else if (LevelFinished_InLow) begin
                    state_d = ST_PLAY;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs are registered from the next state so they line up with the state register.
        adv_low_d   = (state_d != ST_ADVANCE);
        game_over_d = (state_d == ST_DONE);
    end

    // State, level and output registers.
    always_ff @(posedge SC_LEVEL_STATEMACHINE_CLOCK_50 or posedge SC_LEVEL_STATEMACHINE_RESET_InHigh) begin
        if (SC_LEVEL_STATEMACHINE_RESET_InHigh) begin
            state_q     <= ST_IDLE;
            level_q     <= '0;
            adv_low_q   <= 1'b1;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            adv_low_q   <= adv_low_d;
            game_over_q <= game_over_d;
        end
    end

    sc_progress_counter #(
        .WIDTH (PROGRESS_DATAWIDTH)
    ) u_progress (
        .clk       (SC_LEVEL_STATEMACHINE_CLOCK_50),
        .rst       (SC_LEVEL_STATEMACHINE_RESET_InHigh),
        .clear     (prog_clear),
        .enable    (prog_enable),
        .shift_low (ProgressShift_InLow),
        .count_low (ProgressCount_InLow),
        .count     (LvlProgressCount_Out)
    );

    assign CurrentLevel_Out    = level_q;
    assign LevelAdvance_OutLow = adv_low_q;
    assign GameOver_OutHigh    = game_over_q;

endmodule

// File: tb/tb_sc_level_progress_counter.sv
// Bench for sc_level_progress_counter: directed scenarios plus random strobes against a reference model.
module tb_sc_level_progress_counter;

    logic       clk;
    logic       rst;
    logic       start_n;
    logic       shift_n;
    logic       count_n;
    logic       lf_n;
    logic       fg_n;
    logic [2:0] level;
    logic [4:0] progress;
    logic       adv_n;
    logic       game_over;

    int unsigned n_tests;
    int unsigned n_fail;
    int unsigned adv_seen;

    // Reference model: game phase flags, level number, progress and armed increment.
    bit          m_started;
    bit          m_advancing;
    bit          m_waiting;
    bit          m_over;
    int unsigned m_level;
    int unsigned m_progress;
    bit          m_armed;

    sc_level_progress_counter #(
        .LEVEL_DATAWIDTH    (3),
        .PROGRESS_DATAWIDTH (5),
        .LEVEL_MAX          (7)
    ) dut (
        .SC_LEVEL_STATEMACHINE_CLOCK_50     (clk),
        .SC_LEVEL_STATEMACHINE_RESET_InHigh (rst),
        .Start_InLow                        (start_n),
        .ProgressShift_InLow                (shift_n),
        .ProgressCount_InLow                (count_n),
        .LevelFinished_InLow                (lf_n),
        .FinishedGame_InLow                 (fg_n),
        .CurrentLevel_Out                   (level),
        .LvlProgressCount_Out               (progress),
        .LevelAdvance_OutLow                (adv_n),
        .GameOver_OutHigh                   (game_over)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started   = 0;
        m_advancing = 0;
        m_waiting   = 0;
        m_over      = 0;
        m_level     = 0;
        m_progress  = 0;
        m_armed     = 0;
    endtask

    // One clock of game rules, applied to the inputs present at the edge.
    task automatic model_step(input bit st, input bit sh, input bit cn, input bit lf, input bit fg);
        if (!m_started) begin
            if (!st) begin
                m_started  = 1;
                m_level    = 1;
                m_progress = 0;
                m_armed    = 0;
            end
        end else if (m_over) begin
            // frozen until reset
        end else if (m_advancing) begin
            m_advancing = 0;
            if (m_level < 7) m_level = m_level + 1;
            m_progress = 0;
            m_armed    = 0;
            if (m_level == 7) m_over = 1;
            else m_waiting = 1;
        end else if (m_waiting) begin
            if (!fg) m_over = 1;
            else if (lf) m_waiting = 0;
        end else begin
            if (!fg) m_over = 1;
            else if (!lf) m_advancing = 1;
            else begin
                if (!cn && m_armed && m_progress < 31) m_progress = m_progress + 1;
                if (!sh) m_armed = 1;
                else if (!cn) m_armed = 0;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("level", level, m_level);
        check_eq("progress", progress, m_progress);
        check_eq("advance_n", adv_n, m_advancing ? 0 : 1);
        check_eq("game_over", game_over, m_over ? 1 : 0);
    endtask

    // Drive one cycle of inputs, clock it, then compare DUT against the model.
    task automatic cyc(input bit st, input bit sh, input bit cn, input bit lf, input bit fg);
        start_n = st;
        shift_n = sh;
        count_n = cn;
        lf_n    = lf;
        fg_n    = fg;
        @(posedge clk);
        model_step(st, sh, cn, lf, fg);
        #1;
        if (!adv_n) adv_seen++;
        check_outputs();
    endtask

    task automatic idle_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cyc(1, 1, 1, 1, 1);
    endtask

    task automatic pairs(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            cyc(1, 0, 1, 1, 1);
            cyc(1, 1, 0, 1, 1);
        end
    endtask

    // Asynchronous reset applied between edges; outputs must drop immediately.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check_eq("rst_level", level, 0);
        check_eq("rst_progress", progress, 0);
        #3;
        rst = 1'b0;
    endtask

    task automatic advance_once();
        cyc(1, 1, 1, 0, 1);
        idle_cycles(2);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        adv_seen = 0;
        rst      = 1'b0;
        start_n  = 1'b1;
        shift_n  = 1'b1;
        count_n  = 1'b1;
        lf_n     = 1'b1;
        fg_n     = 1'b1;
        model_reset();
        #5;
        do_reset();

        // Start, then progress pairs and lone counts.
        idle_cycles(2);
        cyc(0, 1, 1, 1, 1);
        check_eq("start_level", level, 1);
        pairs(18);
        check_eq("pairs18", progress, 18);
        for (int unsigned i = 0; i < 3; i++) cyc(1, 1, 0, 1, 1);
        check_eq("lone_count", progress, 18);
        cyc(1, 0, 0, 1, 1);
        cyc(1, 1, 0, 1, 1);
        check_eq("shift_count_same", progress, 19);

        // Held level-finished gives exactly one advance.
        advance_once();
        check_eq("level2", level, 2);
        adv_seen = 0;
        for (int unsigned i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1);
        check_eq("one_pulse", adv_seen, 1);
        check_eq("level3", level, 3);
        check_eq("held_progress", progress, 0);
        cyc(1, 1, 1, 1, 1);
        pairs(2);
        check_eq("resumed", progress, 2);

        // Walk to the end level.
        for (int unsigned i = 0; i < 4; i++) advance_once();
        check_eq("end_level", level, 7);
        check_eq("end_over", game_over, 1);
        pairs(3);
        cyc(1, 1, 1, 0, 0);
        check_eq("frozen_level", level, 7);

        // Saturation, then an advance overriding a count in the same cycle.
        do_reset();
        cyc(0, 1, 1, 1, 1);
        pairs(40);
        check_eq("saturate", progress, 31);
        cyc(1, 0, 1, 1, 1);
        cyc(1, 1, 0, 0, 1);
        cyc(1, 1, 1, 1, 1);
        check_eq("adv_clears", progress, 0);

        // Reset in the middle of level 4.
        do_reset();
        cyc(0, 1, 1, 1, 1);
        for (int unsigned i = 0; i < 3; i++) advance_once();
        pairs(12);
        check_eq("pre_rst_level", level, 4);
        check_eq("pre_rst_progress", progress, 12);
        do_reset();

        // Finished-game from PLAY.
        cyc(0, 1, 1, 1, 1);
        cyc(1, 0, 0, 1, 0);
        check_eq("fg_over", game_over, 1);

        // Random strobes against the model.
        for (int unsigned run = 0; run < 8; run++) begin
            do_reset();
            for (int unsigned i = 0; i < 400; i++) begin
                cyc($urandom_range(99) >= 30,
                    $urandom_range(99) >= 45,
                    $urandom_range(99) >= 45,
                    $urandom_range(99) >= 6,
                    $urandom_range(999) >= 3);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
